// File: rtl/pe_pkg.sv
// Shared PE datapath types and helpers for the decomposable adder lanes.
package pe_pkg;

  localparam int ADDER_SEG_LEN = 8;
  localparam int ADDER_N_SEG   = 4;
  localparam int ADDER_MODE_L  = $clog2($clog2(ADDER_N_SEG) + 1);

  typedef logic [ADDER_MODE_L-1:0] adder_mode_t;

  localparam adder_mode_t ADDER_MODE_SEG  = adder_mode_t'(0);
  localparam adder_mode_t ADDER_MODE_FULL = adder_mode_t'($clog2(ADDER_N_SEG));

  // A segment starts a lane when its index is a multiple of 2^mode.
  function automatic logic seg_is_lane_base(input int seg, input int mode);
    return ((seg >> mode) << mode) == seg;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline slice: GRP segment adders with lane-boundary carry masking, then a register slice.
// Subtraction hardware is built only when ADDER_DECOMP_SUB_EN is defined.
module adder_pipe_stage
  import pe_pkg::*;
#(
  parameter int SEG_LEN = ADDER_SEG_LEN,
  parameter int N_SEG   = ADDER_N_SEG,
  parameter int GRP     = 2,
  parameter int STAGE   = 0,
  parameter int MODE_L  = ADDER_MODE_L
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance_i,
  input  logic                     valid_i,
  input  logic [N_SEG*SEG_LEN-1:0] a_i,
  input  logic [N_SEG*SEG_LEN-1:0] b_i,
  input  logic [MODE_L-1:0]        mode_i,
`ifdef ADDER_DECOMP_SUB_EN
  input  logic                     sub_i,
  output logic                     sub_o,
`endif
  input  logic [N_SEG*SEG_LEN-1:0] sum_i,
  input  logic [N_SEG-1:0]         cout_i,
  input  logic                     carry_i,
  output logic                     valid_o,
  output logic [N_SEG*SEG_LEN-1:0] a_o,
  output logic [N_SEG*SEG_LEN-1:0] b_o,
  output logic [MODE_L-1:0]        mode_o,
  output logic [N_SEG*SEG_LEN-1:0] sum_o,
  output logic [N_SEG-1:0]         cout_o,
  output logic                     carry_o
);

  localparam int W    = N_SEG * SEG_LEN;
  localparam int BASE = STAGE * GRP;

  logic [GRP:0]           chain;
  logic [GRP*SEG_LEN-1:0] grp_sum;
  logic [GRP-1:0]         grp_cout;
  logic                   lane_cin;
  logic [W-1:0]           sum_d;
  logic [N_SEG-1:0]       cout_d;

  logic                   valid_q;
  logic [W-1:0]           a_q;
  logic [W-1:0]           b_q;
  logic [MODE_L-1:0]      mode_q;
  logic [W-1:0]           sum_q;
  logic [N_SEG-1:0]       cout_q;
  logic                   carry_q;

`ifdef ADDER_DECOMP_SUB_EN
  logic sub_q;
  assign lane_cin = sub_i;
`else
  assign lane_cin = 1'b0;
`endif

  assign chain[0] = carry_i;

  for (genvar gi = 0; gi < GRP; gi++) begin : g_seg
    localparam int SEG = BASE + gi;
    logic [SEG_LEN-1:0] b_seg;
    logic               cin;
    logic [SEG_LEN:0]   s;
`ifdef ADDER_DECOMP_SUB_EN
    assign b_seg = b_i[SEG*SEG_LEN +: SEG_LEN] ^ {SEG_LEN{sub_i}};
`else
    assign b_seg = b_i[SEG*SEG_LEN +: SEG_LEN];
`endif
    assign cin = seg_is_lane_base(SEG, int'(mode_i)) ? lane_cin : chain[gi];
    assign s   = {1'b0, a_i[SEG*SEG_LEN +: SEG_LEN]} + {1'b0, b_seg} + {{SEG_LEN{1'b0}}, cin};
    assign chain[gi+1] = s[SEG_LEN];
    assign grp_sum[gi*SEG_LEN +: SEG_LEN] = s[SEG_LEN-1:0];
    // Only the top segment of a lane reports its carry-out.
    assign grp_cout[gi] = s[SEG_LEN] & seg_is_lane_base(SEG + 1, int'(mode_i));
  end

  always_comb begin
    sum_d  = sum_i;
    cout_d = cout_i;
    sum_d[BASE*SEG_LEN +: GRP*SEG_LEN] = grp_sum;
    cout_d[BASE +: GRP]                = grp_cout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      sum_q   <= '0;
      cout_q  <= '0;
      carry_q <= 1'b0;
`ifdef ADDER_DECOMP_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (advance_i) begin
      valid_q <= valid_i;
      a_q     <= a_i;
      b_q     <= b_i;
      mode_q  <= mode_i;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= chain[GRP];
`ifdef ADDER_DECOMP_SUB_EN
      sub_q   <= sub_i;
`endif
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign mode_o  = mode_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign carry_o = carry_q;
`ifdef ADDER_DECOMP_SUB_EN
  assign sub_o   = sub_q;
`endif

endmodule

// File: rtl/adder_decomposable_pipelined.sv
// Pipelined decomposable adder: lanes of 2^mode segments, carry chain split over PIPE_STAGES slices.
// Define ADDER_DECOMP_SUB_EN to add the sub port and lane-wise subtraction.
module adder_decomposable_pipelined
  import pe_pkg::*;
#(
  parameter int SEG_LEN     = ADDER_SEG_LEN,
  parameter int N_SEG       = ADDER_N_SEG,
  parameter int PIPE_STAGES = 2,
  parameter int MODE_L      = $clog2($clog2(N_SEG) + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_SEG*SEG_LEN-1:0] in0,
  input  logic [N_SEG*SEG_LEN-1:0] in1,
  input  logic [MODE_L-1:0]        mode,
`ifdef ADDER_DECOMP_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_SEG*SEG_LEN-1:0] out_data,
  output logic [N_SEG-1:0]         out_carry
);

  localparam int W   = N_SEG * SEG_LEN;
  localparam int GRP = N_SEG / PIPE_STAGES;
  localparam logic [MODE_L-1:0] MODE_MAX = MODE_L'($clog2(N_SEG));

  // Index s feeds stage s; index s+1 is stage s's register output.
  logic              vld_s   [PIPE_STAGES+1];
  logic [W-1:0]      a_s     [PIPE_STAGES+1];
  logic [W-1:0]      b_s     [PIPE_STAGES+1];
  logic [MODE_L-1:0] mode_s  [PIPE_STAGES+1];
  logic [W-1:0]      sum_s   [PIPE_STAGES+1];
  logic [N_SEG-1:0]  cout_s  [PIPE_STAGES+1];
  logic              carry_s [PIPE_STAGES+1];
`ifdef ADDER_DECOMP_SUB_EN
  logic              sub_s   [PIPE_STAGES+1];
  assign sub_s[0] = sub;
`endif

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign vld_s[0]   = in_valid;
  assign a_s[0]     = in0;
  assign b_s[0]     = in1;
  assign mode_s[0]  = (mode > MODE_MAX) ? MODE_MAX : mode;
  assign sum_s[0]   = '0;
  assign cout_s[0]  = '0;
  assign carry_s[0] = 1'b0;

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    adder_pipe_stage #(
      .SEG_LEN (SEG_LEN),
      .N_SEG   (N_SEG),
      .GRP     (GRP),
      .STAGE   (gi),
      .MODE_L  (MODE_L)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance_i (advance),
      .valid_i   (vld_s[gi]),
      .a_i       (a_s[gi]),
      .b_i       (b_s[gi]),
      .mode_i    (mode_s[gi]),
`ifdef ADDER_DECOMP_SUB_EN
      .sub_i     (sub_s[gi]),
      .sub_o     (sub_s[gi+1]),
`endif
      .sum_i     (sum_s[gi]),
      .cout_i    (cout_s[gi]),
      .carry_i   (carry_s[gi]),
      .valid_o   (vld_s[gi+1]),
      .a_o       (a_s[gi+1]),
      .b_o       (b_s[gi+1]),
      .mode_o    (mode_s[gi+1]),
      .sum_o     (sum_s[gi+1]),
      .cout_o    (cout_s[gi+1]),
      .carry_o   (carry_s[gi+1])
    );
  end

  assign out_valid = vld_s[PIPE_STAGES];
  assign out_data  = sum_s[PIPE_STAGES];
  assign out_carry = cout_s[PIPE_STAGES];

endmodule

// File: tb/tb_adder_decomposable_pipelined.sv
// Directed bench for adder_decomposable_pipelined (SEG_LEN=8, N_SEG=4, PIPE_STAGES=2).
// Subtraction vectors run only when ADDER_DECOMP_SUB_EN is defined.
module tb_adder_decomposable_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [1:0]  mode;
`ifdef ADDER_DECOMP_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_carry;

  int checks = 0;
  int errors = 0;

  adder_decomposable_pipelined #(
    .SEG_LEN     (8),
    .N_SEG       (4),
    .PIPE_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .mode      (mode),
`ifdef ADDER_DECOMP_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] ed, input logic [3:0] ec);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_carry"}, 32'(out_carry), 32'(ec));
    $display("txn %s: out_data=%h out_carry=%b (expected %h %b)", tag, out_data, out_carry, ed, ec);
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input logic [31:0] ed, input logic [3:0] ec);
    in0 = a; in1 = b; mode = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_not_early"}, 32'(out_valid), 32'd0);
    tick();
    expect_result(tag, ed, ec);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; mode = '0; out_ready = 1'b1;
`ifdef ADDER_DECOMP_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    run_one("m0_seg", 32'h01FF80FF, 32'h01018001, 2'd0, 32'h02000000, 4'b0111);
    run_one("m1_pair", 32'h0000FFFF, 32'h00000001, 2'd1, 32'h00000000, 4'b0010);
    run_one("m2_full", 32'h00FFFFFF, 32'h00000001, 2'd2, 32'h01000000, 4'b0000);
    run_one("m2_wrap", 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000, 4'b1000);
    run_one("m3_clamp", 32'hFFFFFFFF, 32'h00000001, 2'd3, 32'h00000000, 4'b1000);
    run_one("m0_allcarry", 32'hFFFFFFFF, 32'h01010101, 2'd0, 32'h00000000, 4'b1111);

    // Back-to-back modes 0,2,1,0 with the consumer stalled for three cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in0 = 32'h01FF80FF; in1 = 32'h01018001; mode = 2'd0;
    tick();
    check("b2b_in_ready_first", 32'(in_ready), 32'd1);
    in0 = 32'h01FF80FF; in1 = 32'h01018001; mode = 2'd2;
    tick();
    in0 = 32'h12FFFFFF; in1 = 32'h00000001; mode = 2'd1;
    for (int k = 0; k < 3; k++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      expect_result("stall_hold_t0", 32'h02000000, 4'b0111);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(in_ready), 32'd1);
    tick();
    expect_result("b2b_t1_m2", 32'h03010100, 4'b0000);
    in0 = 32'hFFFFFFFF; in1 = 32'h01010101; mode = 2'd0;
    tick();
    in_valid = 1'b0;
    expect_result("b2b_t2_m1", 32'h12FF0000, 4'b0010);
    tick();
    expect_result("b2b_t3_m0", 32'h00000000, 4'b1111);
    tick();
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Reset with two transactions in flight.
    in_valid = 1'b1; in0 = 32'h11111111; in1 = 32'h22222222; mode = 2'd0;
    tick();
    in0 = 32'h0F0F0F0F; in1 = 32'h01010101;
    tick();
    in_valid = 1'b0;
    expect_result("inflight_a", 32'h33333333, 4'b0000);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_out_carry", 32'(out_carry), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("postrst_no_stale", 32'(out_valid), 32'd0);
    end

`ifdef ADDER_DECOMP_SUB_EN
    sub = 1'b1;
    run_one("sub_borrow", 32'h00000005, 32'h00000007, 2'd0, 32'h000000FE, 4'b1110);
    run_one("sub_equal", 32'h12345678, 32'h12345678, 2'd0, 32'h00000000, 4'b1111);
    sub = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
